// File: rtl/btb_update_ctrl.sv
// BTB write-port scheduler: filters branch-resolution updates, queues them in a small FIFO
// and issues one write per cycle; runs a full clear sweep after reset and on invalidate.
module btb_update_ctrl #(
    parameter int IDX_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_upd_valid,
    output logic             o_upd_ready,
    input  logic [31:0]      i_upd_pc,
    input  logic [31:0]      i_upd_tpc,
    input  logic             i_upd_taken,
    input  logic             i_upd_dir_fail,
    input  logic             i_upd_add_fail,
    input  logic             i_inv_req,
    output logic             o_btb_we,
    output logic [IDX_W-1:0] o_btb_waddr,
    output logic [31:0]      o_btb_wdata,
    output logic             o_btb_wvalid,
    output logic             o_lookup_en,
    output logic             o_busy,
    output logic [31:0]      o_cnt_upd,
    output logic [31:0]      o_cnt_fail
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] SWEEP_LAST = '1;
    localparam logic [PTR_W:0]   DEPTH_CNT  = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_sweep;
    logic [IDX_W-1:0]   w_sweep_nxt;

    logic [IDX_W-1:0]   r_q_idx [FIFO_DEPTH];
    logic [31:0]        r_q_tpc [FIFO_DEPTH];
    logic               r_q_vld [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [PTR_W:0]     r_count;

    logic               r_btb_we;
    logic [IDX_W-1:0]   r_btb_waddr;
    logic [31:0]        r_btb_wdata;
    logic               r_btb_wvalid;
    logic [31:0]        r_cnt_upd;
    logic [31:0]        r_cnt_fail;

    logic               w_we_nxt;
    logic [IDX_W-1:0]   w_waddr_nxt;
    logic [31:0]        w_wdata_nxt;
    logic               w_wvalid_nxt;

    logic               w_run;
    logic               w_hs;
    logic               w_flush;
    logic               w_enq;
    logic               w_pop;
    logic               w_fail;
    logic [IDX_W-1:0]   w_upd_idx;

    assign w_run       = (r_state == ST_RUN);
    assign o_upd_ready = w_run && (r_count < DEPTH_CNT);
    assign w_hs        = i_upd_valid && o_upd_ready;
    assign w_flush     = w_run && i_inv_req;
    // Not-taken updates only need a write when they must kill a stale taken entry.
    assign w_enq       = w_hs && !w_flush && (i_upd_taken || i_upd_dir_fail);
    assign w_pop       = w_run && !i_inv_req && (r_count != '0);
    assign w_fail      = i_upd_dir_fail || i_upd_add_fail;
    assign w_upd_idx   = i_upd_pc[IDX_W+2:3];

    assign o_lookup_en  = w_run;
    assign o_busy       = !w_run;
    assign o_btb_we     = r_btb_we;
    assign o_btb_waddr  = r_btb_waddr;
    assign o_btb_wdata  = r_btb_wdata;
    assign o_btb_wvalid = r_btb_wvalid;
    assign o_cnt_upd    = r_cnt_upd;
    assign o_cnt_fail   = r_cnt_fail;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_INIT;
            r_sweep <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sweep <= w_sweep_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_sweep_nxt  = r_sweep;
        w_we_nxt     = 1'b0;
        w_waddr_nxt  = r_btb_waddr;
        w_wdata_nxt  = r_btb_wdata;
        w_wvalid_nxt = r_btb_wvalid;
        case (r_state)
            ST_INIT: begin
                if (i_inv_req) begin
                    w_sweep_nxt = '0;
                end else begin
                    w_we_nxt     = 1'b1;
                    w_waddr_nxt  = r_sweep;
                    w_wdata_nxt  = '0;
                    w_wvalid_nxt = 1'b0;
                    if (r_sweep == SWEEP_LAST) begin
                        w_state_nxt = ST_RUN;
                        w_sweep_nxt = '0;
                    end else begin
                        w_sweep_nxt = r_sweep + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (i_inv_req) begin
                    w_state_nxt = ST_INIT;
                    w_sweep_nxt = '0;
                end else if (w_pop) begin
                    w_we_nxt     = 1'b1;
                    w_waddr_nxt  = r_q_idx[r_rptr];
                    w_wdata_nxt  = r_q_tpc[r_rptr];
                    w_wvalid_nxt = r_q_vld[r_rptr];
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_sweep_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_btb_we     <= 1'b0;
            r_btb_waddr  <= '0;
            r_btb_wdata  <= '0;
            r_btb_wvalid <= 1'b0;
        end else begin
            r_btb_we     <= w_we_nxt;
            r_btb_waddr  <= w_waddr_nxt;
            r_btb_wdata  <= w_wdata_nxt;
            r_btb_wvalid <= w_wvalid_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_q_idx[i] <= '0;
                r_q_tpc[i] <= '0;
                r_q_vld[i] <= 1'b0;
            end
        end else if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_q_idx[r_wptr] <= w_upd_idx;
                r_q_tpc[r_wptr] <= i_upd_taken ? i_upd_tpc : 32'h0;
                r_q_vld[r_wptr] <= i_upd_taken;
                r_wptr          <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_enq, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Statistics survive invalidates; only reset clears them.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt_upd  <= '0;
            r_cnt_fail <= '0;
        end else if (w_hs) begin
            if (r_cnt_upd != '1) begin
                r_cnt_upd <= r_cnt_upd + 1'b1;
            end
            if (w_fail && (r_cnt_fail != '1)) begin
                r_cnt_fail <= r_cnt_fail + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Randomized bench for btb_update_ctrl with a queue-based reference model of the
// sweep, filter and drain behaviour.
module tb_btb_update_ctrl;

    localparam int IDX_W      = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int ENTRIES    = 1 << IDX_W;

    logic             clk;
    logic             rst;
    logic             upd_valid;
    logic             upd_ready;
    logic [31:0]      upd_pc;
    logic [31:0]      upd_tpc;
    logic             upd_taken;
    logic             upd_dir_fail;
    logic             upd_add_fail;
    logic             inv_req;
    logic             btb_we;
    logic [IDX_W-1:0] btb_waddr;
    logic [31:0]      btb_wdata;
    logic             btb_wvalid;
    logic             lookup_en;
    logic             busy;
    logic [31:0]      cnt_upd;
    logic [31:0]      cnt_fail;

    btb_update_ctrl #(.IDX_W(IDX_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_upd_valid    (upd_valid),
        .o_upd_ready    (upd_ready),
        .i_upd_pc       (upd_pc),
        .i_upd_tpc      (upd_tpc),
        .i_upd_taken    (upd_taken),
        .i_upd_dir_fail (upd_dir_fail),
        .i_upd_add_fail (upd_add_fail),
        .i_inv_req      (inv_req),
        .o_btb_we       (btb_we),
        .o_btb_waddr    (btb_waddr),
        .o_btb_wdata    (btb_wdata),
        .o_btb_wvalid   (btb_wvalid),
        .o_lookup_en    (lookup_en),
        .o_busy         (busy),
        .o_cnt_upd      (cnt_upd),
        .o_cnt_fail     (cnt_fail)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model: table clear in progress, or a queue of pending writes.
    typedef struct {
        logic [IDX_W-1:0] idx;
        logic [31:0]      tpc;
        logic             vld;
    } ent_t;

    ent_t             m_q[$];
    bit               m_init;
    int               m_sweep;
    bit               m_we;
    logic [IDX_W-1:0] m_addr;
    logic [31:0]      m_data;
    logic             m_vld;
    logic [31:0]      m_cnt_upd;
    logic [31:0]      m_cnt_fail;

    function automatic void model_reset();
        m_q.delete();
        m_init     = 1'b1;
        m_sweep    = 0;
        m_we       = 1'b0;
        m_cnt_upd  = 32'h0;
        m_cnt_fail = 32'h0;
    endfunction

    function automatic bit m_ready();
        return !m_init && (m_q.size() < FIFO_DEPTH);
    endfunction

    function automatic void model_edge(input bit v, input logic [31:0] pc, input logic [31:0] tpc,
                                       input bit tk, input bit df, input bit af, input bit inv);
        bit   hs;
        ent_t e;
        hs = v && m_ready();
        if (hs) begin
            if (m_cnt_upd != 32'hFFFF_FFFF) m_cnt_upd = m_cnt_upd + 1;
            if ((df || af) && m_cnt_fail != 32'hFFFF_FFFF) m_cnt_fail = m_cnt_fail + 1;
        end
        m_we = 1'b0;
        if (m_init) begin
            if (inv) begin
                m_sweep = 0;
            end else begin
                m_we = 1'b1; m_addr = IDX_W'(m_sweep); m_data = 32'h0; m_vld = 1'b0;
                m_sweep = m_sweep + 1;
                if (m_sweep == ENTRIES) begin
                    m_init  = 1'b0;
                    m_sweep = 0;
                end
            end
        end else if (inv) begin
            m_q.delete();
            m_init  = 1'b1;
            m_sweep = 0;
        end else begin
            if (m_q.size() > 0) begin
                e = m_q.pop_front();
                m_we = 1'b1; m_addr = e.idx; m_data = e.tpc; m_vld = e.vld;
            end
            if (hs && (tk || df)) begin
                e.idx = pc[IDX_W+2:3];
                e.tpc = tk ? tpc : 32'h0;
                e.vld = tk;
                m_q.push_back(e);
            end
        end
    endfunction

    task automatic step(input bit v, input logic [31:0] pc, input logic [31:0] tpc,
                        input bit tk, input bit df, input bit af, input bit inv);
        @(negedge clk);
        upd_valid = v; upd_pc = pc; upd_tpc = tpc;
        upd_taken = tk; upd_dir_fail = df; upd_add_fail = af; inv_req = inv;
        #1;
        chk("upd_ready", upd_ready, m_ready());
        chk("lookup_en", lookup_en, !m_init);
        chk("busy", busy, m_init);
        @(posedge clk);
        model_edge(v, pc, tpc, tk, df, af, inv);
        #1;
        chk("btb_we", btb_we, m_we);
        if (m_we) begin
            chk("btb_waddr", btb_waddr, m_addr);
            chk("btb_wdata", btb_wdata, m_data);
            chk("btb_wvalid", btb_wvalid, m_vld);
        end
        chk("cnt_upd", cnt_upd, m_cnt_upd);
        chk("cnt_fail", cnt_fail, m_cnt_fail);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 32'h0, 32'h0, 0, 0, 0, 0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_we", btb_we, 1'b0);
        chk("rst_waddr", btb_waddr, '0);
        chk("rst_wdata", btb_wdata, 32'h0);
        chk("rst_wvalid", btb_wvalid, 1'b0);
        chk("rst_ready", upd_ready, 1'b0);
        chk("rst_lookup", lookup_en, 1'b0);
        chk("rst_busy", busy, 1'b1);
        chk("rst_cnt_upd", cnt_upd, 32'h0);
        chk("rst_cnt_fail", cnt_fail, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        upd_valid = 0; upd_pc = 0; upd_tpc = 0; upd_taken = 0;
        upd_dir_fail = 0; upd_add_fail = 0; inv_req = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        #1 rst = 1'b0;

        // Power-up sweep then steady RUN.
        idle(ENTRIES + 2);

        // Single taken update: pc 0x1C000048 maps to index 9.
        step(1, 32'h1C00_0048, 32'h1C00_0100, 1, 0, 0, 0);
        idle(1);
        chk("single_addr", btb_waddr, 4'h9);
        chk("single_data", btb_wdata, 32'h1C00_0100);
        idle(1);

        // Filter: ignored not-taken, then invalidating not-taken mispredict.
        step(1, 32'h1C00_0030, 32'h1C00_0500, 0, 0, 0, 0);
        step(1, 32'h1C00_0010, 32'h1C00_0600, 0, 1, 0, 0);
        idle(1);
        chk("inval_addr", btb_waddr, 4'h2);
        idle(2);

        // Back-to-back taken updates.
        for (int i = 0; i < 6; i++)
            step(1, 32'h2000_0000 + 32'(i * 8), 32'h3000_0000 + 32'(i), 1, i[0], 0, 0);
        idle(3);

        // Invalidate mid-traffic, then re-invalidate part way through the sweep.
        for (int i = 0; i < 3; i++)
            step(1, 32'h4000_0000 + 32'(i * 8), 32'h5000_0000 + 32'(i), 1, 0, 1, 0);
        step(1, 32'h4000_0040, 32'h5000_0040, 1, 1, 0, 1);
        idle(8);
        step(0, 32'h0, 32'h0, 0, 0, 0, 1);
        idle(ENTRIES + 3);

        // Randomized traffic with occasional invalidates.
        for (int i = 0; i < 600; i++)
            step(($urandom_range(0, 9) < 7), $urandom, $urandom, $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 59) == 0));
        if (m_init) idle(ENTRIES + 2);

        // Counter saturation.
        @(posedge clk);
        #1;
        force dut.r_cnt_upd  = 32'hFFFF_FFFF;
        force dut.r_cnt_fail = 32'hFFFF_FFFF;
        #1;
        release dut.r_cnt_upd;
        release dut.r_cnt_fail;
        m_cnt_upd  = 32'hFFFF_FFFF;
        m_cnt_fail = 32'hFFFF_FFFF;
        step(1, 32'h1C00_0048, 32'h1C00_0200, 1, 1, 1, 0);
        chk("sat_cnt_upd", cnt_upd, 32'hFFFF_FFFF);
        chk("sat_cnt_fail", cnt_fail, 32'hFFFF_FFFF);
        idle(2);

        // Asynchronous reset in the middle of a sweep.
        step(0, 32'h0, 32'h0, 0, 0, 0, 1);
        idle(5);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs();
        model_reset();
        #1 rst = 1'b0;
        idle(ENTRIES + 4);
        step(1, 32'h0000_0078, 32'hCAFE_0000, 1, 0, 0, 0);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/btb_update_ctrl.md
# btb_update_ctrl

Write-port scheduler for the branch target buffer. Accepts branch-resolution updates from the execute stage and filters out those that need no write. Queues the rest in a small FIFO and issues them one per cycle on the single BTB write port. After reset and on every invalidate request, it sequences a full clear sweep of the table; lookups are held off until the sweep completes.

## Interface
- IDX_W, 8, BTB index width; index = pc[IDX_W+2:3]; table has 2^IDX_W entries
- FIFO_DEPTH, 4, update queue depth; power of two, ≥2

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- upd_valid  in  1  update offered by execute stage
- upd_ready  out  1  update accepted this cycle when upd_valid && upd_ready
- upd_pc  in  32  branch instruction PC
- upd_tpc  in  32  resolved target PC
- upd_taken  in  1  branch actually taken
- upd_dir_fail  in  1  direction mispredicted
- upd_add_fail  in  1  target mispredicted
- inv_req  in  1  single-cycle request: invalidate entire BTB
- btb_we  out  1  BTB write enable (registered)
- btb_waddr  out  IDX_W  BTB write index (registered)
- btb_wdata  out  32  target written (registered)
- btb_wvalid  out  1  entry valid bit written (registered)
- lookup_en  out  1  BTB predictions may be used
- busy  out  1  clear sweep in progress
- cnt_upd  out  32  accepted updates, saturating
- cnt_fail  out  32  accepted updates with dir_fail or add_fail, saturating

## Operation
- States: INIT (clear sweep) and RUN. Reset enters INIT with sweep counter 0, FIFO empty, and both counters 0.
- Reset values: btb_we=0, btb_waddr=0, btb_wdata=0, btb_wvalid=0, upd_ready=0, lookup_en=0, busy=1.
- INIT:
  - Each cycle: btb_we<=1, btb_waddr<=counter, btb_wdata<=0, btb_wvalid<=0, counter++.
  - After the write for index 2^IDX_W−1 is issued, state→RUN and counter→0.
  - upd_ready=0, lookup_en=0, busy=1.
- RUN:
  - upd_ready = (count < FIFO_DEPTH). An enqueue into a full FIFO is not allowed, even with a simultaneous pop.
  - lookup_en=1, busy=0.
- Filter, applied at handshake:
  - upd_taken=1: enqueue {idx, tpc, valid=1}.
  - upd_taken=0 && upd_dir_fail=1: enqueue {idx, 0, valid=0}, which invalidates a stale taken entry.
  - Otherwise: accepted and counted, but not enqueued.
- Drain:
  - If FIFO not empty in RUN: pop head; btb_we<=1 with head fields.
  - If FIFO empty: btb_we<=0.
  - One write per cycle, strictly FIFO order. Same-index entries are not merged; the later one wins.
- inv_req in RUN:
  - At the next edge: FIFO cleared, counter=0, state→INIT.
  - An update handshaking in that same cycle is counted but discarded.
  - The write already on btb_we in that cycle still completes.
- inv_req in INIT: counter reset to 0, so the sweep restarts at index 0.
- Counters:
  - cnt_upd +1 per handshake.
  - cnt_fail +1 per handshake with dir_fail|add_fail.
  - Both hold at 0xFFFFFFFF.
  - Cleared only by rst.
- rst mid-operation: all state returns to reset values immediately. The FIFO contents and any sweep progress are lost.

## Timing
- After reset deassert: first sweep write (index 0) on btb_we at the first edge. The sweep occupies 2^IDX_W consecutive cycles. RUN (lookup_en=1) begins the cycle after the last sweep write is issued.
- Update latency: handshake at edge E0 → btb_we with that entry valid after E1 (one cycle in FIFO, registered output) → BTB captures at E2. This assumes the FIFO was empty.
- Throughput: one write per cycle. With continuous filtered traffic, upd_ready stays 1.
- upd_ready is combinational from state and count only; it never depends on upd_valid.
- Pointer wrap: read and write pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.

## Test plan
- Reset sweep, IDX_W=4: release rst → btb_we=1 for exactly 16 cycles, btb_waddr 0..15, wvalid=0 → then lookup_en=1, busy=0, upd_ready=1.
- Single taken update: pc=0x1C000048, tpc=0x1C000100, taken=1 → two edges later btb_we=1, waddr=0x9, wdata=0x1C000100, wvalid=1. cnt_upd=1, cnt_fail=0.
- Filter: taken=0, dir_fail=0 → no btb_we, cnt_upd+1. Then taken=0, dir_fail=1, pc=0x1C000010 → write waddr=0x2, wvalid=0; cnt_fail=1.
- Backpressure, FIFO_DEPTH=4: 6 back-to-back taken updates → all 6 writes emerge in order on consecutive cycles, no loss. Then block the drain by entering INIT with inv_req and confirm upd_ready=0.
- Invalidate mid-traffic: 3 entries queued, assert inv_req → at most the in-flight write completes, the queued entries never appear, and a 16-write sweep follows. inv_req again at sweep index 7 → sweep restarts at 0.
- Async reset mid-sweep and counter saturation: rst pulse between edges → outputs at reset values immediately. Force cnt_upd=0xFFFFFFFF, then one handshake → value stays 0xFFFFFFFF.
